// File: rtl/serial_rx_loader_pkg.sv
// Shared definitions for the serial receive front end: FSM state encoding
// and default frame geometry.
package serial_rx_defs;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/serial_rx_loader_sync2.sv
// Two-flop synchronizer for an asynchronous level input. It resets to 1 so
// that an idle-high line produces no spurious edge when reset is released.
module sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= D;
            sync_q <= meta_q;
        end
    end

    assign Q = sync_q;

endmodule

// File: rtl/serial_rx_loader.sv
// UART-style deserialiser: start/WIDTH data (LSB first)/stop. It emits one ENA
// strobe per well-framed word, or one ERR strobe when the stop bit is low.
module serial_rx_loader
    import serial_rx_defs::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    output logic [WIDTH-1:0] DATA,
    output logic             ENA,
    output logic             ERR,
    output logic             BUSY
);

    localparam int CCW = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [CCW-1:0] HALF_LAST = CCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CCW-1:0] BIT_LAST  = CCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] WORD_LAST = BCW'(WIDTH - 1);

    logic             s_sync;
    logic             s_prev_q;
    logic             fall;
    state_e           state_q;
    logic [CCW-1:0]   cyc_q;
    logic [BCW-1:0]   bit_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] data_q;
    logic             ena_q;
    logic             err_q;

    sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (SIN),
        .Q   (s_sync)
    );

    // A frame starts only on a real high-to-low transition, never on a low level.
    assign fall = s_prev_q & ~s_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_prev_q <= 1'b1;
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            ena_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s_prev_q <= s_sync;
            ena_q    <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_START;
                        cyc_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cyc_q == HALF_LAST) begin
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        state_q <= s_sync ? ST_IDLE : ST_SHIFT;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cyc_q == BIT_LAST) begin
                        cyc_q   <= '0;
                        // Shifting in at the MSB leaves the first bit at the LSB.
                        shreg_q <= WIDTH'({s_sync, shreg_q} >> 1);
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == WORD_LAST) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cyc_q == BIT_LAST) begin
                        cyc_q   <= '0;
                        state_q <= ST_IDLE;
                        if (s_sync) begin
                            data_q <= shreg_q;
                            ena_q  <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DATA = data_q;
    assign ENA  = ena_q;
    assign ERR  = err_q;
    assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_loader.sv
// Bench for serial_rx_loader: a line-history frame model checked every cycle,
// plus directed frames with literal data, latency and pulse-count expectations.
module tb_serial_rx_loader;

    localparam int W    = 8;
    localparam int CPB  = 16;
    localparam int LMAX = 4096;
    // Positions relative to f, the first clock whose SIN sample is low.
    localparam int MID    = CPB / 2;
    localparam int REJ    = MID + 2;
    localparam int STOP_S = MID + (W + 1) * CPB;
    localparam int DONE   = STOP_S + 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         SIN = 1'b1;
    logic [W-1:0] DATA;
    logic         ENA;
    logic         ERR;
    logic         BUSY;

    serial_rx_loader #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .SIN  (SIN),
        .DATA (DATA),
        .ENA  (ENA),
        .ERR  (ERR),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic line [0:LMAX-1];

    // Line history as seen at each rising edge; reset holds the synchronizer at 1.
    initial line[0] = 1'b1;
    always @(posedge CLK) begin
        cyc           <= cyc + 1;
        line[cyc + 1] <= RST ? SIN : 1'b1;
    end

    logic [W-1:0] R = '0;
    always @(posedge CLK) if (ENA) R <= DATA;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int           m_f    = -1;
    int           m_from = 1;
    logic [W-1:0] m_data = '0;
    int           ena_cnt = 0, err_cnt = 0, busy_cnt = 0, ena_cyc = 0;
    logic [W-1:0] ena_log [$];

    always @(negedge CLK) begin
        int           c;
        logic         e_ena, e_err, e_busy;
        logic [W-1:0] d;
        c = cyc;
        e_ena = 1'b0; e_err = 1'b0; e_busy = 1'b0; d = '0;
        if (!RST) begin
            m_f = -1; m_data = '0; m_from = c + 1;
        end else begin
            if (m_f >= 0) begin
                if (c >= m_f + 2 && c < m_f + REJ) e_busy = 1'b1;
                else if (c == m_f + REJ && line[m_f + MID] == 1'b1) begin
                    m_from = m_f + REJ - 1; m_f = -1;
                end else if (c >= m_f + REJ && c < m_f + DONE) e_busy = 1'b1;
                else if (c == m_f + DONE) begin
                    if (line[m_f + STOP_S]) begin
                        for (int k = 0; k < W; k++) d[k] = line[m_f + MID + CPB * (k + 1)];
                        m_data = d; e_ena = 1'b1;
                    end else e_err = 1'b1;
                    m_from = m_f + DONE - 1; m_f = -1;
                end
            end
            if (m_f < 0) begin
                for (int f = (m_from < 1 ? 1 : m_from); f <= c; f++) begin
                    if (line[f-1] == 1'b1 && line[f] == 1'b0) begin
                        m_f = f;
                        break;
                    end
                end
                if (m_f < 0) m_from = c + 1;
            end
        end
        check("model_ENA", ENA, e_ena);
        check("model_ERR", ERR, e_err);
        check("model_BUSY", BUSY, e_busy);
        check("model_DATA", DATA, m_data);
        if (ENA) begin ena_cnt++; ena_cyc = c; ena_log.push_back(DATA); end
        if (ERR) err_cnt++;
        if (BUSY) busy_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic v);
        SIN = v;
        wait_cyc(CPB);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int k = 0; k < W; k++) send_bit(d[k]);
        send_bit(stop);
    endtask

    initial begin
        int e0, r0, b0, d0, d1;
        logic [W-1:0] v55;
        RST = 1'b0; SIN = 1'b1;
        wait_cyc(1);
        for (int i = 0; i < 5; i++) begin
            SIN = ~SIN;
            wait_cyc(1);
            check("rst_DATA", DATA, 8'h00);
            check("rst_ENA_ERR_BUSY", {ENA, ERR, BUSY}, 3'b000);
        end
        SIN = 1'b1;
        wait_cyc(2);
        RST = 1'b1;
        wait_cyc(20);

        // Single valid frame
        e0 = ena_cnt; d0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_cyc(20);
        check("a5_pulses", ena_cnt - e0, 1);
        check("a5_latency", ena_cyc - d0, 155);
        check("a5_DATA", DATA, 8'hA5);
        check("a5_no_err", err_cnt, 0);

        // Back-to-back frames
        e0 = ena_cnt; d0 = cyc;
        send_frame(8'h3C, 1'b1);
        d1 = cyc;
        send_frame(8'hFF, 1'b1);
        wait_cyc(20);
        check("b2b_pulses", ena_cnt - e0, 2);
        check("b2b_first", ena_log[ena_log.size() - 2], 8'h3C);
        check("b2b_latency", ena_cyc - d1, 155);
        check("b2b_DATA", DATA, 8'hFF);
        check("b2b_R", R, 8'hFF);

        // Framing error, then the line is stuck low
        e0 = ena_cnt; r0 = err_cnt;
        send_frame(8'h81, 1'b0);
        SIN = 1'b0;
        wait_cyc(100);
        check("ferr_err", err_cnt - r0, 1);
        check("ferr_no_ena", ena_cnt - e0, 0);
        check("ferr_DATA", DATA, 8'hFF);
        check("ferr_idle", BUSY, 1'b0);
        SIN = 1'b1;
        wait_cyc(20);
        check("ferr_rise_idle", BUSY, 1'b0);

        // Short low glitch rejected at the start-bit midpoint
        e0 = ena_cnt; r0 = err_cnt; b0 = busy_cnt;
        SIN = 1'b0;
        wait_cyc(4);
        SIN = 1'b1;
        wait_cyc(30);
        check("glitch_busy_cycles", busy_cnt - b0, 8);
        check("glitch_no_strobe", (ena_cnt - e0) + (err_cnt - r0), 0);

        // Reset in the middle of data bit 4
        e0 = ena_cnt;
        v55 = 8'h55;
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(v55[k]);
        SIN = v55[4];
        wait_cyc(8);
        check("mid_busy_before", BUSY, 1'b1);
        RST = 1'b0;
        #1;
        check("mid_rst_DATA", DATA, 8'h00);
        check("mid_rst_BUSY", BUSY, 1'b0);
        wait_cyc(3);
        SIN = 1'b1;
        RST = 1'b1;
        wait_cyc(20);
        check("mid_no_ena", ena_cnt - e0, 0);
        d0 = cyc;
        send_frame(8'h12, 1'b1);
        wait_cyc(20);
        check("post_rst_pulses", ena_cnt - e0, 1);
        check("post_rst_latency", ena_cyc - d0, 155);
        check("post_rst_DATA", DATA, 8'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_rx_loader.md
Name: serial_rx_loader

Overview:
- Serial-to-parallel front end that sits directly upstream of the 8-bit enabled register.
- Deserialises an asynchronous UART-style frame on a single line: one start bit (0), WIDTH data bits LSB first, one stop bit (1).
- Presents the assembled word on DATA with a one-cycle ENA strobe, so the register captures exactly one word per valid frame.

Parameters:
- WIDTH, 8, data bits per frame and width of DATA.
- CLKS_PER_BIT, 16, CLK cycles per serial bit period; must be even and >= 4.

Ports:
- CLK   input   1      system clock, rising edge.
- RST   input   1      asynchronous, active-low reset.
- SIN   input   1      serial line, asynchronous to CLK, idles high.
- DATA  output  WIDTH  last correctly framed word; drives register DATA.
- ENA   output  1      one-cycle strobe, DATA valid; drives register ENA.
- ERR   output  1      one-cycle strobe on framing error (stop bit sampled 0).
- BUSY  output  1      high whenever state != IDLE.

Behaviour:
- Reset:
  - One clock, CLK. RST is asynchronous and active-low.
  - RST low immediately forces DATA=0, ENA=0, ERR=0, BUSY=0, state=IDLE, bit counter=0, cycle counter=0.
  - Synchronizer flops and edge-detect flop reset to 1 (idle line).
- SIN passes through a 2-flop synchronizer (s_sync). An edge-detect flop holds the previous s_sync value. A falling edge is s_prev=1 and s_sync=0.
- States: IDLE, START, SHIFT, STOP.
- IDLE:
  - BUSY=0.
  - On a falling edge, go to START and clear the cycle counter.
  - A level-low line without a preceding high never starts a frame.
- START:
  - Count CLKS_PER_BIT/2 - 1 further cycles (mid-bit), then sample s_sync.
  - Sample 0: go to SHIFT, clear cycle and bit counters.
  - Sample 1: glitch; return to IDLE, no strobe.
- SHIFT:
  - Every CLKS_PER_BIT cycles, sample s_sync into the shift register at bit index = bit counter (LSB first), then increment the bit counter.
  - After sampling bit WIDTH-1, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample s_sync.
  - Sample 1: DATA <= shift register, ENA=1 for exactly the next cycle, go to IDLE.
  - Sample 0: ERR=1 for exactly the next cycle, DATA unchanged, go to IDLE.
  - Because IDLE needs a falling edge, a line stuck low after an error does not retrigger.
- Timing:
  - ENA and ERR are registered and never both high.
  - ENA is high for one cycle only, even when frames are back to back.
  - Latency from the s_sync falling edge to ENA high = CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT + 1 cycles. Default: 8+144+1 = 153.
  - SIN to s_sync adds 2 cycles.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. ENA for frame N coincides with IDLE, and IDLE detects the next falling edge without loss.
- SIN changes mid-bit away from sample points are ignored. Only the mid-bit samples matter.
- RST asserted mid-frame aborts the frame immediately: no ENA, DATA returns to 0. After RST deasserts, the line must go high then low to start a new frame.
- Counters:
  - Cycle counter width = clog2(CLKS_PER_BIT).
  - Bit counter width = clog2(WIDTH+1).
  - Neither counter wraps during a legal frame.

Decomposition:
- Shared package/header serial_rx_defs holds:
  - state encoding constants ST_IDLE=2'd0, ST_START=2'd1, ST_SHIFT=2'd2, ST_STOP=2'd3;
  - the default CLKS_PER_BIT and WIDTH values.
- One sub-module, sync2: a 2-flop synchronizer with async active-low reset to 1 (ports CLK, RST, D, Q). It is reusable by other asynchronous inputs.
- The FSM, counters and shift register stay in serial_rx_loader.

Test Plan:
- Reset: hold RST=0 for 5 cycles with SIN toggling -> DATA=8'h00, ENA=0, ERR=0, BUSY=0 throughout.
- Valid frame 8'hA5 (SIN bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles) -> ENA high exactly 1 cycle, 153 cycles after the s_sync fall; DATA=8'hA5; ERR stays 0.
- Back-to-back frames 8'h3C then 8'hFF with no idle gap -> two single-cycle ENA pulses; DATA=8'h3C then 8'hFF; downstream register R ends at 8'hFF.
- Framing error: frame 8'h81 with stop bit 0, then line held low 100 cycles -> ERR 1 cycle, no ENA, DATA keeps the previous value, no restart until SIN rises then falls.
- Glitch: SIN low for 4 cycles then high -> START rejects at mid-bit; BUSY high about 8 cycles then 0; no ENA, no ERR.
- Mid-frame reset: RST low during data bit 4 of frame 8'h55 -> immediate DATA=0, BUSY=0; a following clean frame 8'h12 gives ENA with DATA=8'h12.
